// File: rtl/spi_flash_responder_if.sv
// SPI link between a flash master and the spi_flash_responder device end.
interface spi_flash_responder_if;
    logic SCK;
    logic CSX;
    logic SDI;
    logic SDO;

    modport master (output SCK, output CSX, output SDI, input SDO);
    modport slave  (input SCK, input CSX, input SDI, output SDO);
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave emulating the read side of a W25Q16BV flash (READ, JEDEC ID,
// READ STATUS); read data comes from an external byte-wide memory port.
module spi_flash_responder #(
    parameter int unsigned ADDR_W   = 21,
    parameter logic [23:0] JEDEC_ID = 24'hEF4015,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_flash_responder_if.slave spi,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic              active,
    output logic [7:0]        cmd
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE} state_t;

    state_t            state;
    logic [1:0]        sck_sync, csx_sync, sdi_sync;
    logic              sck_prev;
    logic              armed;
    logic [2:0]        bit_cnt;
    logic [1:0]        addr_bytes;
    logic [1:0]        id_idx;
    logic [6:0]        shift_in;
    logic [ADDR_W-2:0] addr_sr;
    logic [7:0]        shift_out;
    logic              sdo;

    logic              sck_rise, sck_fall, byte_done, presenting;
    logic [7:0]        cmd_next, out_byte;
    logic [ADDR_W-1:0] addr_next;

    assign spi.SDO = sdo;

    always_comb begin
        sck_rise   = sck_sync[1] & ~sck_prev;
        sck_fall   = ~sck_sync[1] & sck_prev;
        byte_done  = sck_rise && (bit_cnt == 3'd7);
        cmd_next   = {shift_in, sdi_sync[1]};
        addr_next  = {addr_sr, sdi_sync[1]};
        presenting = (state == DATA) || (state == ID) || (state == STAT);
        out_byte   = (state == DATA) ? mem_data : shift_out;
    end

    // CSX synchroniser resets to 0 so a CSX held low through reset never looks
    // like a fresh select; the block must see CSX high before it arms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= '0;
            csx_sync <= '0;
            sdi_sync <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], spi.SCK};
            csx_sync <= {csx_sync[0], spi.CSX};
            sdi_sync <= {sdi_sync[0], spi.SDI};
            sck_prev <= sck_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            armed      <= 1'b0;
            bit_cnt    <= '0;
            addr_bytes <= '0;
            id_idx     <= '0;
            shift_in   <= '0;
            addr_sr    <= '0;
            shift_out  <= '0;
            sdo        <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            active     <= 1'b0;
            cmd        <= '0;
        end else begin
            mem_rd <= 1'b0;
            active <= ~csx_sync[1];
            if (csx_sync[1]) begin
                state    <= IDLE;
                armed    <= 1'b1;
                bit_cnt  <= '0;
                shift_in <= '0;
                sdo      <= 1'b0;
            end else begin
                if (sck_rise && state != IDLE)
                    bit_cnt <= bit_cnt + 3'd1;
                // At a byte boundary the fall presents the freshly loaded byte
                // instead of shifting, so bytes run back to back.
                if (sck_fall && state != IDLE) begin
                    if (bit_cnt == 3'd0) begin
                        shift_out <= out_byte;
                        sdo       <= presenting & out_byte[7];
                    end else begin
                        shift_out <= {shift_out[6:0], 1'b0};
                        sdo       <= presenting & shift_out[6];
                    end
                end
                case (state)
                    IDLE: begin
                        if (armed) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            shift_in <= cmd_next[6:0];
                            if (bit_cnt == 3'd7) begin
                                cmd <= cmd_next;
                                case (cmd_next)
                                    8'h03: begin
                                        state      <= ADDR;
                                        addr_bytes <= '0;
                                    end
                                    8'h9F: begin
                                        state     <= ID;
                                        shift_out <= JEDEC_ID[23:16];
                                        id_idx    <= 2'd1;
                                    end
                                    8'h05: begin
                                        state     <= STAT;
                                        shift_out <= STATUS;
                                    end
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            addr_sr <= addr_next[ADDR_W-2:0];
                            if (bit_cnt == 3'd7) begin
                                if (addr_bytes == 2'd2) begin
                                    mem_addr <= addr_next;
                                    mem_rd   <= 1'b1;
                                    state    <= DATA;
                                end else begin
                                    addr_bytes <= addr_bytes + 2'd1;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (byte_done) begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            mem_rd   <= 1'b1;
                        end
                    end
                    ID: begin
                        if (byte_done) begin
                            case (id_idx)
                                2'd1: begin
                                    shift_out <= JEDEC_ID[15:8];
                                    id_idx    <= 2'd2;
                                end
                                2'd2: begin
                                    shift_out <= JEDEC_ID[7:0];
                                    id_idx    <= 2'd3;
                                end
                                default: shift_out <= 8'h00;
                            endcase
                        end
                    end
                    STAT: begin
                        if (byte_done)
                            shift_out <= STATUS;
                    end
                    IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: stimulus queues expected MISO bytes
// and memory strobe addresses; monitors pop and compare as the DUT produces them.
module tb_spi_flash_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [20:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 8'h00;
    logic        active;
    logic [7:0]  cmd;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_sdo[$];
    logic [20:0] exp_addr[$];

    always #5 clk = ~clk;

    spi_flash_responder_if spi();

    spi_flash_responder #(
        .ADDR_W  (21),
        .JEDEC_ID(24'hEF4015),
        .STATUS  (8'h00)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .spi     (spi.slave),
        .mem_addr(mem_addr),
        .mem_rd  (mem_rd),
        .mem_data(mem_data),
        .active  (active),
        .cmd     (cmd)
    );

    // Memory model: mem[a] = a[7:0] ^ 8'hA5, data valid the clock after mem_rd.
    always @(posedge clk)
        if (mem_rd) mem_data <= mem_addr[7:0] ^ 8'hA5;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // MISO monitor: master samples SDO on SCK rise; partial bytes are dropped at CSX high.
    int         nbits = 0;
    logic [7:0] rx = 8'h00;
    always @(posedge spi.SCK or posedge spi.CSX) begin
        if (spi.CSX || !rst_n) begin
            nbits = 0;
        end else begin
            rx = {rx[6:0], spi.SDO};
            nbits++;
            if (nbits == 8) begin
                nbits = 0;
                if (exp_sdo.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sdo_unexpected got %h want none", rx);
                end else begin
                    check("sdo_byte", 32'(rx), 32'(exp_sdo.pop_front()));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && mem_rd) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_rd_unexpected got addr %h want no strobe", mem_addr);
            end else begin
                check("mem_rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_bit(input logic b);
        spi.SDI = b;
        clk_n(3);
        spi.SCK = 1'b1;
        clk_n(6);
        spi.SCK = 1'b0;
        clk_n(3);
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] exp);
        exp_sdo.push_back(exp);
        for (int i = 7; i >= 0; i--) sck_bit(tx[i]);
    endtask

    task automatic cs_low();
        spi.CSX = 1'b0;
        clk_n(6);
    endtask

    task automatic cs_high();
        clk_n(3);
        spi.CSX = 1'b1;
        clk_n(8);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        spi.SCK = 1'b0;
        spi.CSX = 1'b0;
        spi.SDI = 1'b0;
        rst_n   = 1'b0;

        // Reset with CSX low and SCK toggling
        for (int i = 0; i < 4; i++) begin
            clk_n(3);
            spi.SCK = 1'b1;
            spi.SDI = ~spi.SDI;
            clk_n(3);
            spi.SCK = 1'b0;
        end
        check("rst_sdo", 32'(spi.SDO), 32'(0));
        check("rst_mem_rd", 32'(mem_rd), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_active", 32'(active), 32'(0));
        check("rst_cmd", 32'(cmd), 32'(0));

        // Released with CSX still low: no response until CSX cycles
        rst_n = 1'b1;
        clk_n(8);
        xfer(8'h9F, 8'h00);
        xfer(8'h00, 8'h00);
        check("post_rst_cmd", 32'(cmd), 32'(0));
        cs_high();

        // READ 03 00 00 10 + 3 bytes
        cs_low();
        xfer(8'h03, 8'h00);
        xfer(8'h00, 8'h00);
        xfer(8'h00, 8'h00);
        exp_addr.push_back(21'h000010);
        xfer(8'h10, 8'h00);
        exp_addr.push_back(21'h000011);
        xfer(8'h00, 8'hB5);
        exp_addr.push_back(21'h000012);
        xfer(8'h00, 8'hB4);
        exp_addr.push_back(21'h000013);
        xfer(8'h00, 8'hB7);
        cs_high();
        check("read_cmd", 32'(cmd), 32'h03);

        // JEDEC ID + 4 bytes
        cs_low();
        xfer(8'h9F, 8'h00);
        xfer(8'h00, 8'hEF);
        xfer(8'h00, 8'h40);
        xfer(8'h00, 8'h15);
        xfer(8'h00, 8'h00);
        cs_high();
        check("jedec_cmd", 32'(cmd), 32'h9F);

        // Address wrap at 2^21
        cs_low();
        xfer(8'h03, 8'h00);
        xfer(8'hFF, 8'h00);
        xfer(8'hFF, 8'h00);
        exp_addr.push_back(21'h1FFFFF);
        xfer(8'hFF, 8'h00);
        exp_addr.push_back(21'h000000);
        xfer(8'h00, 8'h5A);
        exp_addr.push_back(21'h000001);
        xfer(8'h00, 8'hA5);
        cs_high();

        // Abort after 12 address bits, then clean JEDEC and STATUS reads
        cs_low();
        xfer(8'h03, 8'h00);
        xfer(8'hFF, 8'h00);
        for (int i = 0; i < 4; i++) sck_bit(1'b1);
        cs_high();
        check("abort_active", 32'(active), 32'(0));
        cs_low();
        xfer(8'h9F, 8'h00);
        xfer(8'h00, 8'hEF);
        xfer(8'h00, 8'h40);
        xfer(8'h00, 8'h15);
        cs_high();
        cs_low();
        xfer(8'h05, 8'h00);
        xfer(8'h00, 8'h00);
        xfer(8'h00, 8'h00);
        cs_high();
        check("status_cmd", 32'(cmd), 32'h05);

        // Unknown command
        cs_low();
        xfer(8'hFF, 8'h00);
        xfer(8'hA5, 8'h00);
        xfer(8'h5A, 8'h00);
        check("ignore_active", 32'(active), 32'(1));
        check("ignore_cmd", 32'(cmd), 32'hFF);
        check("ignore_sdo", 32'(spi.SDO), 32'(0));
        cs_high();
        check("ignore_inactive", 32'(active), 32'(0));

        clk_n(10);
        check("sdo_queue_drained", 32'(exp_sdo.size()), 32'(0));
        check("addr_queue_drained", 32'(exp_addr.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
